// File: rtl/uart_tx_block_sender.sv
// uart_tx_block_sender
// Reads a block of NUM_BYTES bytes from the UART byte DP-RAM and shifts each
// one out LSB first as an 8N1 frame (start, 8 data, stop) at CLOCKS_PER_BIT
// clocks per bit. A start pulse launches the block; tx_done pulses for one
// cycle on the first idle cycle after the last stop bit.
// Optional build macro UART_TX_PARITY_EN inserts an even-parity bit after
// data bit 7, giving an 11-bit frame.
module uart_tx_block_sender #(
    parameter int CLOCKS_PER_BIT = 500,
    parameter int ADDR_WIDTH     = 9,
    parameter int NUM_BYTES      = 512
) (
    input  logic                  clock_50,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] ram_address,
    input  logic [7:0]            ram_read_data,
    output logic                  uart_tx,
    output logic                  tx_clock_enable,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int TIMER_WIDTH = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(CLOCKS_PER_BIT - 1);
    localparam logic [ADDR_WIDTH-1:0]  ADDR_LAST  = ADDR_WIDTH'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                  state_reg, state_next;
    // The address starts at 0 with every block and steps with every byte, so it
    // also serves as the byte counter.
    logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
    logic [TIMER_WIDTH-1:0]  timer_reg, timer_next;
    logic [2:0]              bit_idx_reg, bit_idx_next;
    logic [7:0]              shift_reg, shift_next;
    logic                    tx_reg, tx_next;
    logic                    done_reg, done_next;
    logic                    bit_done;
`ifdef UART_TX_PARITY_EN
    logic                    parity_reg, parity_next;
`endif

    assign bit_done = (timer_reg == TIMER_LAST);

    // State, counters and the registered serial line.
    always_ff @(posedge clock_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            addr_reg    <= '0;
            timer_reg   <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            timer_reg   <= timer_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            done_reg    <= done_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    // Next-state logic; the line value is derived from the next state so the
    // pin changes on the same edge as the state.
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        timer_next   = timer_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        done_next    = 1'b0;
        tx_next      = 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    addr_next  = '0;
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_LOAD;
            end
            S_LOAD: begin
                shift_next  = ram_read_data;
                timer_next  = '0;
`ifdef UART_TX_PARITY_EN
                parity_next = ^ram_read_data;
`endif
                state_next  = S_START;
            end
            S_START: begin
                if (bit_done) begin
                    timer_next   = '0;
                    bit_idx_next = 3'd0;
                    state_next   = S_DATA;
                end else begin
                    timer_next = timer_reg + TIMER_WIDTH'(1);
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    timer_next   = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end else begin
                    timer_next = timer_reg + TIMER_WIDTH'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    timer_next = '0;
                    state_next = S_STOP;
                end else begin
                    timer_next = timer_reg + TIMER_WIDTH'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    timer_next = '0;
                    if (addr_reg == ADDR_LAST) begin
                        // Last byte: the address is left as-is, never wrapped.
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        addr_next  = addr_reg + ADDR_WIDTH'(1);
                        state_next = S_FETCH;
                    end
                end else begin
                    timer_next = timer_reg + TIMER_WIDTH'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        case (state_next)
            S_START: tx_next = 1'b0;
            S_DATA:  tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    assign ram_address     = addr_reg;
    assign uart_tx         = tx_reg;
    assign tx_done         = done_reg;
    assign tx_busy         = (state_reg != S_IDLE);
    assign tx_clock_enable = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_tx_block_sender.sv
// Bench for uart_tx_block_sender: instance A uses the production bit period
// with a single-byte block, instance B a short bit period with a 16-byte block
// covering the full address range.
`timescale 1ns/1ps
module tb_uart_tx_block_sender;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int CPB_A = 500;
    localparam int AW_A  = 9;
    localparam int NB_A  = 1;
    localparam int CPB_B = 8;
    localparam int AW_B  = 4;
    localparam int NB_B  = 16;
    localparam int P_A   = FB * CPB_A + 2;
    localparam int P_B   = FB * CPB_B + 2;

    logic clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    logic            rst_n_a, rst_n_b, start_a, start_b;
    logic [AW_A-1:0] addr_a;
    logic [AW_B-1:0] addr_b;
    logic [7:0]      rd_a, rd_b;
    logic            tx_a, tx_b, en_a, en_b, busy_a, busy_b, done_a, done_b;
    logic [7:0]      mem_a [0:(1<<AW_A)-1];
    logic [7:0]      mem_b [0:(1<<AW_B)-1];
    bit              chk_on = 1'b0;

    int tests = 0;
    int fails = 0;

    uart_tx_block_sender #(.CLOCKS_PER_BIT(CPB_A), .ADDR_WIDTH(AW_A), .NUM_BYTES(NB_A)) dut_a (
        .clock_50(clock_50), .rst_n(rst_n_a), .start(start_a), .ram_address(addr_a),
        .ram_read_data(rd_a), .uart_tx(tx_a), .tx_clock_enable(en_a), .tx_busy(busy_a),
        .tx_done(done_a));

    uart_tx_block_sender #(.CLOCKS_PER_BIT(CPB_B), .ADDR_WIDTH(AW_B), .NUM_BYTES(NB_B)) dut_b (
        .clock_50(clock_50), .rst_n(rst_n_b), .start(start_b), .ram_address(addr_b),
        .ram_read_data(rd_b), .uart_tx(tx_b), .tx_clock_enable(en_b), .tx_busy(busy_b),
        .tx_done(done_b));

    // DP-RAM read ports: data valid one cycle after the address.
    always @(posedge clock_50) begin
        rd_a <= mem_a[addr_a];
        rd_b <= mem_b[addr_b];
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Line level at a given offset inside one byte slot (2-cycle gap, then the frame).
    function automatic logic exp_line(input int cpb, input int off, input logic [7:0] b);
        int bit_n;
        if (off < 2) return 1'b1;
        bit_n = (off - 2) / cpb;
        if (bit_n == 0) return 1'b0;
        if (bit_n <= 8) return b[bit_n-1];
        if (FB == 11 && bit_n == 9) return ^b;
        return 1'b1;
    endfunction

    // Block-level model: cycles elapsed since the accepting edge, nothing more.
    bit m_act_a = 0, m_done_a = 0, m_act_b = 0, m_done_b = 0;
    int m_c_a = 0, m_c_b = 0;

    always @(posedge clock_50 or negedge rst_n_a) begin
        if (!rst_n_a) begin
            m_act_a <= 0; m_done_a <= 0; m_c_a <= 0;
        end else if (m_act_a) begin
            if (m_c_a == NB_A * P_A - 1) begin m_act_a <= 0; m_done_a <= 1; end
            m_c_a <= m_c_a + 1;
        end else begin
            m_done_a <= 0;
            if (start_a) begin m_act_a <= 1; m_c_a <= 0; end
        end
    end

    always @(posedge clock_50 or negedge rst_n_b) begin
        if (!rst_n_b) begin
            m_act_b <= 0; m_done_b <= 0; m_c_b <= 0;
        end else if (m_act_b) begin
            if (m_c_b == NB_B * P_B - 1) begin m_act_b <= 0; m_done_b <= 1; end
            m_c_b <= m_c_b + 1;
        end else begin
            m_done_b <= 0;
            if (start_b) begin m_act_b <= 1; m_c_b <= 0; end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock_50) begin : cmp
        int  ja, jb;
        logic la, lb;
        if (chk_on) begin
            ja = m_c_a / P_A;
            jb = m_c_b / P_B;
            la = m_act_a ? exp_line(CPB_A, m_c_a % P_A, mem_a[ja % (1<<AW_A)]) : 1'b1;
            lb = m_act_b ? exp_line(CPB_B, m_c_b % P_B, mem_b[jb % (1<<AW_B)]) : 1'b1;
            check("cyc_a{tx,busy,en,done}", {28'd0, tx_a, busy_a, en_a, done_a},
                  {28'd0, la, m_act_a, m_act_a, m_done_a});
            check("cyc_b{tx,busy,en,done}", {28'd0, tx_b, busy_b, en_b, done_b},
                  {28'd0, lb, m_act_b, m_act_b, m_done_b});
            if (m_act_a) check("addr_a", 32'(addr_a), 32'(ja % (1<<AW_A)));
            if (m_act_b) check("addr_b", 32'(addr_b), 32'(jb % (1<<AW_B)));
        end
    end

    // Single byte on instance A: fall latency, bit-centre samples, done latency.
    task automatic run_single(input logic [7:0] b, input logic [10:0] exp_bits, input int exp_done);
        int fall, done_k, ndone, ns;
        logic [10:0] got;
        fall = -1; done_k = -1; ndone = 0; ns = 0; got = '0;
        mem_a[0] = b;
        @(posedge clock_50); #1 start_a = 1'b1;
        @(posedge clock_50); #1 start_a = 1'b0;
        for (int k = 1; k <= P_A + 50; k++) begin
            @(posedge clock_50); #1;
            if (fall < 0 && tx_a === 1'b0) fall = k;
            if (fall >= 0 && ns < FB && k == fall + CPB_A/2 + CPB_A*ns) begin
                got[ns] = tx_a;
                ns++;
            end
            if (done_a === 1'b1) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
        end
        $display("[TB] single byte %02h: fall=%0d samples=%b done_at=%0d", b, fall, got, done_k);
        check("a_fall_latency", 32'(fall), 32'd2);
        check("a_sample_count", 32'(ns), 32'(FB));
        check("a_bit_samples", 32'(got), 32'(exp_bits));
        check("a_done_latency", 32'(done_k), 32'(exp_done));
        check("a_done_pulses", 32'(ndone), 32'd1);
    endtask

    // Block on instance B received by a bit-centre sampling host model.
    task automatic rx_block_b(input string tag, input bit inject);
        logic [7:0]  rx_q[$];
        logic [10:0] sh;
        int t, ns, ndone, ferr;
        bit in_frame;
        t = 0; ns = 0; ndone = 0; ferr = 0; in_frame = 0; sh = '0;
        @(posedge clock_50); #1 start_b = 1'b1;
        @(posedge clock_50); #1 start_b = 1'b0;
        for (int k = 1; k <= NB_B * P_B + 40; k++) begin
            @(posedge clock_50); #1;
            if (start_b) start_b = 1'b0;
            if (inject && rx_q.size() == 3 && in_frame && t == 20) start_b = 1'b1;
            if (!in_frame) begin
                if (tx_b === 1'b0) begin in_frame = 1; t = 0; ns = 0; end
            end else begin
                t++;
            end
            if (in_frame && t == CPB_B/2 + CPB_B*ns) begin
                sh[ns] = tx_b;
                ns++;
                if (ns == FB) begin
                    if (sh[0] !== 1'b0 || sh[FB-1] !== 1'b1) ferr++;
                    if (FB == 11 && sh[9] !== ^sh[8:1]) ferr++;
                    rx_q.push_back(sh[8:1]);
                    in_frame = 0;
                end
            end
            if (done_b === 1'b1) ndone++;
        end
        $display("[TB] block %s: %0d bytes, %0d frame errors, %0d done pulses", tag, rx_q.size(), ferr, ndone);
        check({tag, "_byte_count"}, 32'(rx_q.size()), 32'(NB_B));
        check({tag, "_frame_errors"}, 32'(ferr), 32'd0);
        check({tag, "_done_pulses"}, 32'(ndone), 32'd1);
        for (int i = 0; i < rx_q.size() && i < NB_B; i++)
            check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(mem_b[i]));
    endtask

    initial begin : main
        int idle_bad, kd, kd2;
        rst_n_a = 1'b1; rst_n_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        for (int i = 0; i < (1<<AW_A); i++) mem_a[i] = 8'hEE;
        for (int i = 0; i < (1<<AW_B); i++) mem_b[i] = 8'(i * 29 + 53);
        mem_b[0]  = 8'h00;
        mem_b[10] = 8'h0F;
        mem_b[15] = 8'hFF;
        #2 rst_n_a = 1'b0; rst_n_b = 1'b0;
        #1 chk_on = 1'b1;
        repeat (3) @(posedge clock_50);
        #1 rst_n_a = 1'b1; rst_n_b = 1'b1;
        check("rst_tx_a", 32'(tx_a), 32'd1);
        check("rst_busy_a", 32'(busy_a), 32'd0);
        check("rst_addr_b", 32'(addr_b), 32'd0);
        check("rst_done_b", 32'(done_b), 32'd0);

        idle_bad = 0;
        repeat (2000) begin
            @(posedge clock_50); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) idle_bad++;
        end
        $display("[TB] idle 2000 cycles: %0d bad cycles", idle_bad);
        check("idle_a", 32'(idle_bad), 32'd0);

`ifdef UART_TX_PARITY_EN
        run_single(8'hA5, 11'b10101001010, 5502);
        run_single(8'h07, 11'b11000001110, 5502);
        run_single(8'h03, 11'b10000000110, 5502);
`else
        run_single(8'hA5, 11'b01101001010, 5002);
        run_single(8'h07, 11'b01000001110, 5002);
`endif

        rx_block_b("blk", 1'b0);
        rx_block_b("inj", 1'b1);

        // Start held high across done relaunches on the next cycle.
        @(posedge clock_50); #1 start_b = 1'b1;
        kd = -1;
        for (int k = 0; k <= NB_B * P_B + 40 && kd < 0; k++) begin
            @(posedge clock_50); #1;
            if (done_b === 1'b1) kd = k;
        end
        $display("[TB] held start: done at %0d", kd);
`ifdef UART_TX_PARITY_EN
        check("hold_done_latency", 32'(kd), 32'd1440);
`else
        check("hold_done_latency", 32'(kd), 32'd1312);
`endif
        @(posedge clock_50); #1 start_b = 1'b0;
        check("hold_restart_busy", 32'(busy_b), 32'd1);
        kd2 = -1;
        for (int k = 0; k <= NB_B * P_B + 40 && kd2 < 0; k++) begin
            @(posedge clock_50); #1;
            if (done_b === 1'b1) kd2 = k;
        end
        check("hold_second_done_seen", 32'(kd2 >= 0), 32'd1);

        // Reset during data bit 4 of byte 10.
        @(posedge clock_50); #1 start_b = 1'b1;
        @(posedge clock_50); #1 start_b = 1'b0;
        repeat (10 * P_B + 2 + CPB_B * 5 + 3) @(posedge clock_50);
        #1;
        check("pre_rst_addr", 32'(addr_b), 32'd10);
        check("pre_rst_line", 32'(tx_b), 32'd0);
        rst_n_b = 1'b0;
        #1;
        $display("[TB] reset mid-frame: tx=%b busy=%b addr=%0d", tx_b, busy_b, addr_b);
        check("rst_async_tx", 32'(tx_b), 32'd1);
        check("rst_async_busy", 32'(busy_b), 32'd0);
        check("rst_async_addr", 32'(addr_b), 32'd0);
        idle_bad = 0;
        repeat (3) begin
            @(posedge clock_50); #1;
            if (done_b !== 1'b0) idle_bad++;
        end
        check("rst_no_done", 32'(idle_bad), 32'd0);
        rst_n_b = 1'b1;
        rx_block_b("post_rst", 1'b0);

        repeat (5) @(posedge clock_50);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
